// File: rtl/fpu_unpack_pipe.sv
// FPU operand unpack stage: NaN-box enforcement, sign extraction and X/Y classification,
// held in a registered main entry backed by a one-entry skid buffer.
module fpu_unpack_pipe (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        InValid,
    output logic        InReady,
    input  logic [63:0] X,
    input  logic [63:0] Y,
    input  logic        Fmt,
    input  logic [1:0]  OpCtrl,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [63:0] Xq,
    output logic [63:0] Yq,
    output logic        Xs,
    output logic        Ys,
    output logic        FmtQ,
    output logic [1:0]  OpCtrlQ,
    output logic        XNaN,
    output logic        XSNaN,
    output logic        XInf,
    output logic        XZero,
    output logic        XSubnorm,
    output logic        YNaN,
    output logic        YSNaN,
    output logic        YInf,
    output logic        YZero,
    output logic        YSubnorm
);

    localparam int FLEN    = 64;
    localparam int CLS_W   = 6;
    localparam int ENTRY_W = 2 * FLEN + 2 * CLS_W + 1 + 2;

    localparam logic [FLEN-1:0] CANON_NAN = 64'hFFFFFFFF_7FC00000;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    // Single-precision values whose upper word is not all ones are replaced by the canonical NaN.
    function automatic logic [FLEN-1:0] box_fix(input logic [FLEN-1:0] op, input logic fmt);
        if (!fmt && (op[63:32] != 32'hFFFF_FFFF)) begin
            return CANON_NAN;
        end
        return op;
    endfunction

    // Returns {sign, nan, snan, inf, zero, subnorm} of an already box-corrected operand.
    function automatic logic [CLS_W-1:0] classify(input logic [FLEN-1:0] op, input logic fmt);
        logic sign, exp_ones, exp_zero, frac_zero, frac_msb;
        if (fmt) begin
            sign      = op[63];
            exp_ones  = &op[62:52];
            exp_zero  = ~|op[62:52];
            frac_zero = ~|op[51:0];
            frac_msb  = op[51];
        end else begin
            sign      = op[31];
            exp_ones  = &op[30:23];
            exp_zero  = ~|op[30:23];
            frac_zero = ~|op[22:0];
            frac_msb  = op[22];
        end
        return {sign,
                exp_ones & ~frac_zero,
                exp_ones & ~frac_zero & ~frac_msb,
                exp_ones & frac_zero,
                exp_zero & frac_zero,
                exp_zero & ~frac_zero};
    endfunction

    logic [1:0]         state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [ENTRY_W-1:0] main_q, skid_q;
    logic [ENTRY_W-1:0] in_entry;
    logic [FLEN-1:0]    x_fix, y_fix;
    logic               accept, advance;
    logic               load_main, load_skid, move_skid;

    always_comb begin
        x_fix    = box_fix(X, Fmt);
        y_fix    = box_fix(Y, Fmt);
        in_entry = {x_fix, y_fix, classify(x_fix, Fmt), classify(y_fix, Fmt), Fmt, OpCtrl};
    end

    assign accept  = InValid & in_ready_q;
    assign advance = (state_q != EMPTY) & OutReady;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        load_main = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (accept && advance) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = TWO;
                    end else if (advance) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (advance) begin
                        move_skid = 1'b1;
                        state_d   = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    // Entry registers: main feeds the outputs, skid absorbs one op under backpressure
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            if (load_main) begin
                main_q <= in_entry;
            end else if (move_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    assign InReady  = in_ready_q;
    assign OutValid = (state_q != EMPTY);
    assign {Xq, Yq,
            Xs, XNaN, XSNaN, XInf, XZero, XSubnorm,
            Ys, YNaN, YSNaN, YInf, YZero, YSubnorm,
            FmtQ, OpCtrlQ} = main_q;

endmodule

// File: doc/fpu_unpack_pipe.md
# fpu_unpack_pipe

Pipelined operand-unpack stage feeding the FPU sign-injection, min/max and classify logic. Accepts raw 64-bit register-file operands with a valid/ready handshake. Enforces NaN-boxing for single precision, extracts sign bits, and classifies X and Y. Results go into a registered output with a one-entry skid buffer, so downstream backpressure never drops or reorders operations.

## Interface
- FLEN, 64, operand width. Fixed; the block supports exactly two sizes: D is 64-bit, S is 32-bit.
- clk  in  1  clock. One clock domain.
- reset_n  in  1  reset. Asynchronous assert, active-low.
- flush  in  1  synchronous kill of all held operations.
- InValid  in  1  upstream operation valid.
- InReady  out  1  stage can accept an operation.
- X, Y  in  64  raw operands.
- Fmt  in  1  format: 1 = double, 0 = single.
- OpCtrl  in  2  passed through unchanged to the consumer.
- OutValid  out  1  output entry valid.
- OutReady  in  1  consumer accepts the output entry.
- Xq, Yq  out  64  box-corrected operands.
- Xs, Ys  out  1  operand signs.
- FmtQ  out  1  registered Fmt.
- OpCtrlQ  out  2  registered OpCtrl.
- XNaN, XSNaN, XInf, XZero, XSubnorm  out  1 each  X class flags.
- YNaN, YSNaN, YInf, YZero, YSubnorm  out  1 each  Y class flags.

## Operation
- Box check applies only when Fmt=0. If X[63:32] != 32'hFFFFFFFF, X is replaced by canonical boxed NaN 64'hFFFFFFFF_7FC00000. Y is checked the same way.
- When Fmt=1, operands pass through unmodified.
- Sign bit: bit 63 for D, bit 31 of the corrected operand for S.
- Field positions:
  - D: exponent [62:52], fraction [51:0].
  - S: exponent [30:23], fraction [22:0].
- Classification, computed on the corrected operand:
  - NaN = exponent all ones and fraction != 0.
  - SNaN = NaN and fraction MSB = 0.
  - Inf = exponent all ones and fraction = 0.
  - Zero = exponent 0 and fraction 0.
  - Subnorm = exponent 0 and fraction != 0.
- Exactly one of NaN, Inf, Zero, Subnorm is set per operand, or none of them for normal values.
- Storage is two entries: main (drives the outputs) and skid.
- Accept condition: InValid & InReady.
- Advance condition: OutValid & OutReady.
- Entry state machine, where state is the count of valid entries:
  - EMPTY: accept loads main; go to ONE.
  - ONE, advance with no accept: go to EMPTY.
  - ONE, accept with no advance: load skid; go to TWO.
  - ONE, accept and advance in the same cycle: load main with the new input; stay in ONE.
  - TWO: InReady=0. On advance, move skid into main; go to ONE.
- Operations leave in accept order.
- flush=1 clears both valid bits on the next edge. A same-cycle accept is discarded and state becomes EMPTY. Flush has priority over every other event.
- Data registers load only on accept or on a skid→main move. They hold their value otherwise.

## Timing
- Latency is one cycle: an operation accepted at edge N appears on the outputs after edge N with OutValid=1.
- Throughput is one operation per cycle while OutReady=1.
- InReady is registered: InReady = (state != TWO). It does not depend combinationally on OutReady.
- Outputs are stable while OutValid=1 and OutReady=0.
- Reset values:
  - OutValid=0, InReady=1, state EMPTY.
  - All data and flag outputs 0; FmtQ=0; OpCtrlQ=0.
- Reset asserted mid-operation discards all entries immediately. Out-of-reset, the first accept is possible on the first clk edge after reset_n rises.
- OutValid=0 while EMPTY. Data outputs are don't-care then but must not toggle.

## Test plan
- Reset behaviour: assert reset_n=0 with entries in TWO → immediately OutValid=0, InReady=1, Xq=0. Release → accept succeeds on the next edge.
- Single precision, properly boxed:
  - X=64'hFFFFFFFF_BF800000, Fmt=0 → Xq unchanged, Xs=1, all class flags 0.
  - Y=64'hFFFFFFFF_7F800001 → YNaN=1, YSNaN=1.
- Single precision, bad box: X=64'h00000000_3F800000, Fmt=0 → Xq=64'hFFFFFFFF_7FC00000, XNaN=1, XSNaN=0, Xs=0.
- Double precision:
  - X=64'h8000000000000000 → XZero=1, Xs=1.
  - Y=64'h000F000000000000 → YSubnorm=1.
  - Y=64'h7FF0000000000000 → YInf=1.
- Backpressure: stream ops A, B, C with OutReady=0 → A held, B goes to skid, InReady=0, C not accepted. Raise OutReady → outputs A, B, C in order with no loss.
- Flush: in TWO, assert flush with InValid=1 → next cycle OutValid=0, InReady=1, and the flushed input is never output.
